// File: rtl/mag_frame_unpacker_pkg.sv
// +-----------------------------------------------------------------------+
// | mag_frame_pkg - shared frame constants and state encoding (Rev 1.0)   |
// +-----------------------------------------------------------------------+
`default_nettype none

package mag_frame_pkg;
  localparam int          FRAME_BYTES    = 10;
  localparam int          TIMEOUT_CYCLES = 255;
  localparam logic [7:0]  SYNC_BYTE      = 8'h4D;
  localparam logic [7:0]  TRAILER_HEAD   = 8'hA2;
  localparam logic [7:0]  TRAILER_FILL   = 8'hAA;
  // Bytes 4..9 of a frame, byte 4 in the low bits.
  localparam logic [47:0] TRAILER_WORD   = {{5{TRAILER_FILL}}, TRAILER_HEAD};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } frame_state_e;
endpackage

`default_nettype wire

// File: rtl/mag_frame_unpacker_if.sv
// +-----------------------------------------------------------------------+
// | mag_frame_unpacker_if - SRAM byte handshake and frame outputs (Rev 1.0)|
// +-----------------------------------------------------------------------+
`default_nettype none

interface mag_frame_unpacker_if;
  import mag_frame_pkg::*;

  logic                       start;
  logic [7:0]                 d_read;
  logic                       byte_valid;
  logic                       next_byte;
  logic [8*FRAME_BYTES-1:0]   mag_data;
  logic [23:0]                timestamp;
  logic                       frame_valid;
  logic                       sync_err;
  logic                       timeout_err;
  logic                       busy;

  modport master (
    input  start, d_read, byte_valid,
    output next_byte, mag_data, timestamp, frame_valid, sync_err, timeout_err, busy
  );

  modport slave (
    output start, d_read, byte_valid,
    input  next_byte, mag_data, timestamp, frame_valid, sync_err, timeout_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/mag_frame_unpacker_byte_timeout_ctr.sv
// +-----------------------------------------------------------------------+
// | byte_timeout_ctr - 8-bit saturating wait counter (Rev 1.0)            |
// +-----------------------------------------------------------------------+
`default_nettype none

module byte_timeout_ctr
  import mag_frame_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam logic [7:0] LIM    = 8'(LIMIT);
  localparam logic [7:0] LIM_M1 = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // High in the cycle whose increment reaches the limit, so the caller can act on the same edge.
  assign expired = (count == LIM) || (inc && (count == LIM_M1));
endmodule

`default_nettype wire

// File: rtl/mag_frame_unpacker.sv
// +-----------------------------------------------------------------------+
// | mag_frame_unpacker - reads one 10-byte frame back from SRAM (Rev 1.0) |
// | MAG_TRAILER_CHECK_EN: also validate trailer bytes 4..9 at DONE.       |
// +-----------------------------------------------------------------------+
`default_nettype none

module mag_frame_unpacker
  import mag_frame_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  mag_frame_unpacker_if.master bus
);
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_REQ    = ST_REQ;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_DONE   = ST_DONE;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  logic [1:0]                state;
  logic [3:0]                idx;
  logic [8*FRAME_BYTES-1:0]  shadow;
  logic [8*FRAME_BYTES-1:0]  shadow_next;
  logic [8*FRAME_BYTES-1:0]  mag_data;
  logic                      frame_valid;
  logic                      sync_err;
  logic                      timeout_err;
  logic                      busy;
  logic                      trailer_ok;
  logic                      expired;

  always_comb begin
    shadow_next = shadow;
    shadow_next[{idx, 3'b000} +: 8] = bus.d_read;
  end

`ifdef MAG_TRAILER_CHECK_EN
  assign trailer_ok = (shadow_next[79:32] == TRAILER_WORD);
`else
  assign trailer_ok = 1'b1;
`endif

  byte_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == S_REQ),
    .inc     ((state == S_WAIT) && !bus.byte_valid),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      shadow      <= '0;
      mag_data    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy still set here means an error pulse is showing; drop it before accepting START.
          if (busy) begin
            busy <= 1'b0;
          end else if (bus.start) begin
            state  <= S_REQ;
            idx    <= '0;
            shadow <= '0;
            busy   <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.byte_valid) begin
            shadow <= shadow_next;
            if ((idx == 4'd0) && (bus.d_read != SYNC_BYTE)) begin
              sync_err <= 1'b1;
              state    <= S_IDLE;
            end else if (idx == LAST_IDX) begin
              // Commit on entry to DONE so the new word and its pulse appear together.
              state <= S_DONE;
              if (trailer_ok) begin
                mag_data    <= shadow_next;
                frame_valid <= 1'b1;
              end else begin
                sync_err <= 1'b1;
              end
            end else begin
              idx   <= idx + 4'd1;
              state <= S_REQ;
            end
          end else if (expired) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.next_byte   = (state == S_REQ);
  assign bus.mag_data    = mag_data;
  assign bus.timestamp   = mag_data[31:8];
  assign bus.frame_valid = frame_valid;
  assign bus.sync_err    = sync_err;
  assign bus.timeout_err = timeout_err;
  assign bus.busy        = busy;
endmodule

`default_nettype wire

// File: tb/tb_mag_frame_unpacker.sv
// +-----------------------------------------------------------------------+
// | tb_mag_frame_unpacker - scoreboard bench for mag_frame_unpacker (Rev 1.0)|
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mag_frame_unpacker;
  import mag_frame_pkg::*;

  localparam logic [2:0] K_FV = 3'b100;
  localparam logic [2:0] K_SE = 3'b010;
  localparam logic [2:0] K_TE = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    int          cyc;
    logic [79:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mag_frame_unpacker_if bus ();

  mag_frame_unpacker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          t0 = 0;
  int          nb_count = 0;
  int          resp_idx = 0;
  int          stall_at = 99;
  bit          noise = 1'b0;
  bit          prev_req = 1'b0;
  logic [7:0]  frame [10];
  logic [79:0] last_good = '0;
  exp_t        sbq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic load_frame(input logic [79:0] word);
    for (int i = 0; i < 10; i++) frame[i] = word[8*i +: 8];
  endtask

  // Issue START at the current negedge; kind 0 means no terminal pulse is expected.
  task automatic kick(input logic [2:0] kind, input int lat, input logic [79:0] data);
    exp_t e;
    t0 = cyc;
    if (kind != 3'b000) begin
      e.kind = kind;
      e.cyc  = t0 + lat;
      e.data = data;
      sbq.push_back(e);
    end
    resp_idx = 0;
    nb_count = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.busy, 0);
  endtask

  // Responder: answers a NEXT_BYTE one cycle later; optional noise on BYTE_VALID during requests.
  initial begin
    bus.byte_valid = 1'b0;
    bus.d_read     = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_req && resp_idx < stall_at) begin
        bus.byte_valid = 1'b1;
        bus.d_read     = frame[resp_idx];
        resp_idx++;
      end else if (noise && bus.next_byte) begin
        bus.byte_valid = 1'b1;
        bus.d_read     = 8'hFF;
      end else begin
        bus.byte_valid = 1'b0;
        bus.d_read     = 8'h00;
      end
      prev_req = bus.next_byte;
    end
  end

  // Monitor: every terminal pulse must match the head of the scoreboard.
  initial begin
    exp_t       e;
    logic [2:0] kind;
    forever begin
      @(negedge clk);
      if (bus.next_byte) nb_count++;
      kind = {bus.frame_valid, bus.sync_err, bus.timeout_err};
      if (kind != 3'b000) begin
        if (sbq.size() == 0) begin
          check("unexpected_pulse", kind, 0);
        end else begin
          e = sbq.pop_front();
          check("pulse_kind", kind, e.kind);
          check("pulse_cycle", cyc, e.cyc);
          if (e.kind == K_FV) begin
            check("mag_data", bus.mag_data, e.data);
            check("timestamp", bus.timestamp, e.data[31:8]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [79:0] FR_A = 80'hAAAAAAAAAAA21234564D;
  localparam logic [79:0] FR_S = 80'hAAAAAAAAAAA21234564C;
  localparam logic [79:0] FR_B = 80'hAAAAAAAAAAA23322114D;
  localparam logic [79:0] FR_C = 80'hAAAAAAAAAAA20302014D;
  localparam logic [79:0] FR_T = 80'hAAAAABAAAAA21234564D;

  initial begin
    bus.start = 1'b0;
    load_frame(FR_A);
    repeat (3) @(negedge clk);
    check("reset_flags", {bus.busy, bus.next_byte, bus.frame_valid, bus.sync_err, bus.timeout_err}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_mag", bus.mag_data, 0);
    check("reset_ts", bus.timestamp, 0);

    // Good frame, 1-cycle responder.
    kick(K_FV, 21, FR_A);
    wait_idle("good_idle", 100);
    check("good_busy_fall", cyc, t0 + 22);
    check("good_nb_count", nb_count, 10);
    last_good = FR_A;

    // Bad sync byte.
    load_frame(FR_S);
    kick(K_SE, 3, '0);
    wait_idle("sync_idle", 100);
    check("sync_busy_fall", cyc, t0 + 4);
    check("sync_nb_count", nb_count, 1);
    check("sync_mag_kept", bus.mag_data, last_good);

    // Stall on the third request, then restart on the cycle BUSY falls.
    load_frame(FR_A);
    stall_at = 2;
    kick(K_TE, 261, '0);
    wait_idle("to_idle", 400);
    check("to_busy_fall", cyc, t0 + 262);
    check("to_nb_count", nb_count, 3);
    check("to_mag_kept", bus.mag_data, last_good);
    stall_at = 99;
    load_frame(FR_B);
    kick(K_FV, 21, FR_B);
    wait_idle("after_to_idle", 100);
    last_good = FR_B;

    // Mid-frame START pulses and BYTE_VALID noise during requests.
    load_frame(FR_C);
    noise = 1'b1;
    kick(K_FV, 21, FR_C);
    for (int i = 0; i < 20; i++) begin
      bus.start = (i % 4 == 1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle("noise_idle", 100);
    noise = 1'b0;
    check("noise_nb_count", nb_count, 10);
    last_good = FR_C;

    // Reset while waiting for byte 5.
    load_frame(FR_A);
    kick(3'b000, 0, '0);
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_flags", {bus.busy, bus.next_byte, bus.frame_valid, bus.sync_err, bus.timeout_err}, 0);
    check("rst_mag", bus.mag_data, 0);
    check("rst_ts", bus.timestamp, 0);
    @(negedge clk);
    reset = 1'b0;
    last_good = '0;
    repeat (3) @(negedge clk);
    kick(K_FV, 21, FR_A);
    wait_idle("post_rst_idle", 100);
    last_good = FR_A;

    // Trailer byte 7 corrupted.
    load_frame(FR_T);
`ifdef MAG_TRAILER_CHECK_EN
    kick(K_SE, 21, '0);
    wait_idle("trailer_idle", 100);
    check("trailer_mag_kept", bus.mag_data, last_good);
`else
    kick(K_FV, 21, FR_T);
    wait_idle("trailer_idle", 100);
    last_good = FR_T;
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire
